// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and memory (slave): req/ack handshake,
// where write fields travel with req and read data is valid with ack.
interface mem_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one req/ack bus access per aligned memory op, done_o two cycles after
// valid_i at best; stall_o holds upstream until the access completes or times out (berr_o).
module mem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  mem_lsu_if.master   bus,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic [31:0] badvaddr_o,
  output logic        berr_o
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d, we_q, we_d, drop_q, drop_d;
  logic          sext_q, sext_d, berr_q, berr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]    lane_q, lane_d, size_q, size_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          is_load, is_store, sext_op, misaligned, start, timeout_hit, dropping;
  logic [1:0]    size_op;
  logic [3:0]    be_op;
  logic [31:0]   wdata_op, load_ext;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;

  // size_op: 0 byte, 1 halfword, 2 word
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext_op  = 1'b0;
    size_op  = 2'd0;
    case (op_i)
      4'd1: begin is_load  = 1'b1; sext_op = 1'b1; size_op = 2'd0; end
      4'd2: begin is_load  = 1'b1;                 size_op = 2'd0; end
      4'd3: begin is_load  = 1'b1; sext_op = 1'b1; size_op = 2'd1; end
      4'd4: begin is_load  = 1'b1;                 size_op = 2'd1; end
      4'd5: begin is_load  = 1'b1;                 size_op = 2'd2; end
      4'd6: begin is_store = 1'b1;                 size_op = 2'd0; end
      4'd7: begin is_store = 1'b1;                 size_op = 2'd1; end
      4'd8: begin is_store = 1'b1;                 size_op = 2'd2; end
      default: ;
    endcase
    misaligned = ((size_op == 2'd1) && addr_i[0]) ||
                 ((size_op == 2'd2) && (addr_i[1:0] != 2'b00));
    be_op    = 4'b1111;
    wdata_op = wdata_i;
    case (size_op)
      2'd0: begin be_op = 4'b0001 << addr_i[1:0]; wdata_op = {4{wdata_i[7:0]}}; end
      2'd1: begin be_op = addr_i[1] ? 4'b1100 : 4'b0011; wdata_op = {2{wdata_i[15:0]}}; end
      default: ;
    endcase
  end

  assign adel_o     = valid_i && is_load  && misaligned && !flush_i;
  assign ades_o     = valid_i && is_store && misaligned && !flush_i;
  assign badvaddr_o = (adel_o || ades_o) ? addr_i : 32'd0;
  assign start      = (state_q == IDLE) && valid_i && (is_load || is_store) && !misaligned && !flush_i;

  // The counter value is the number of REQ cycles already spent without ack.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);
  assign dropping    = drop_q || flush_i;

  always_comb begin
    ld_b     = 8'(bus.bus_rdata >> {lane_q, 3'b000});
    ld_h     = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    load_ext = bus.bus_rdata;
    case (size_q)
      2'd0:    load_ext = {{24{sext_q & ld_b[7]}}, ld_b};
      2'd1:    load_ext = {{16{sext_q & ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lane_d  = lane_q;
    size_d  = size_q;
    sext_d  = sext_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    berr_d  = berr_q;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          stall_o = 1'b1;
          req_d   = 1'b1;
          we_d    = is_store;
          be_d    = be_op;
          addr_d  = {addr_i[31:2], 2'b00};
          wdata_d = is_store ? wdata_op : 32'd0;
          lane_d  = addr_i[1:0];
          size_d  = size_op;
          sext_d  = sext_op;
          drop_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
        if (flush_i) drop_d = 1'b1;
        if (bus.bus_ack || timeout_hit) begin
          req_d = 1'b0;
          if (dropping) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            rdata_d = (bus.bus_ack && !we_q) ? load_ext : 32'd0;
            berr_d  = !bus.bus_ack;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        rdata_d = 32'd0;
        berr_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      sext_q  <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign done_o        = (state_q == DONE);
  assign rdata_o       = rdata_q;
  assign berr_o        = berr_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed and random load/store accesses against a byte-lane reference model; the bench plays the bus slave.
module tb_mem_lsu;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, flush_i;
  logic [3:0]  op_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, adel_o, ades_o, berr_o;
  logic [31:0] rdata_o, badvaddr_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_lsu_if bif ();

  mem_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .flush_i(flush_i), .bus(bif), .stall_o(stall_o),
    .done_o(done_o), .rdata_o(rdata_o), .adel_o(adel_o), .ades_o(ades_o),
    .badvaddr_o(badvaddr_o), .berr_o(berr_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, lane from addr%4, replication by multiplication, extension by masking.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, output bit mem, output bit ld, output bit mis,
                                output logic [3:0] be, output logic [31:0] bw, output logic [31:0] lr);
    int unsigned sz, lane;
    bit          sg;
    logic [31:0] v, m;
    mem  = (op >= 4'd1) && (op <= 4'd8);
    ld   = mem && (op <= 4'd5);
    sz   = (op == 4'd1 || op == 4'd2 || op == 4'd6) ? 1 :
           (op == 4'd3 || op == 4'd4 || op == 4'd7) ? 2 : 4;
    sg   = (op == 4'd1) || (op == 4'd3);
    lane = a % 4;
    mis  = mem && ((a % sz) != 0);
    be   = 4'(((1 << sz) - 1) << lane);
    bw   = (sz == 1) ? {24'd0, wd[7:0]} * 32'h01010101 :
           (sz == 2) ? {16'd0, wd[15:0]} * 32'h00010001 : wd;
    v    = rd >> (8 * lane);
    if (sz == 4) begin
      lr = v;
    end else begin
      m  = (32'd1 << (8 * sz)) - 32'd1;
      v  = v & m;
      lr = (sg && v[8*sz-1]) ? (v | ~m) : v;
    end
  endfunction

  // ack_after: REQ cycle (1-based) in which ack is raised, 0 = never; flush_cyc: REQ cycle carrying flush_i.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_after, input int flush_cyc);
    bit          mem, ld, mis, acked, exp_done, exp_berr, fin;
    logic [3:0]  be;
    logic [31:0] bw, lr, got_rd;
    logic        got_berr, prev_req;
    int          exp_req, stall_cnt, req_cyc, rises, dones;
    model(op, a, wd, rd, mem, ld, mis, be, bw, lr);
    stall_cnt = 0; req_cyc = 0; rises = 0; dones = 0;
    fin = 1'b0; prev_req = 1'b0; got_rd = 32'd0; got_berr = 1'b0;
    @(negedge clk);
    valid_i = 1'b1; op_i = op; addr_i = a; wdata_i = wd; flush_i = 1'b0;
    bif.bus_ack = 1'b0; bif.bus_rdata = rd;
    #1;
    chk1("adel", adel_o, ld && mis);
    chk1("ades", ades_o, mem && !ld && mis);
    chk("badvaddr", badvaddr_o, (mem && mis) ? a : 32'd0);
    if (!mem || mis) begin
      for (int i = 0; i < 3; i++) begin
        if (i > 0) begin @(negedge clk); #1; end
        chk1("no_stall", stall_o, 1'b0);
        chk1("no_req", bif.bus_req, 1'b0);
      end
      valid_i = 1'b0;
      return;
    end
    acked    = (ack_after >= 1) && (ack_after <= int'(TO));
    exp_req  = acked ? ack_after : int'(TO);
    exp_done = !((flush_cyc >= 1) && (flush_cyc <= exp_req));
    exp_berr = exp_done && !acked;
    for (int cyc = 0; cyc < 30 && !fin; cyc++) begin
      if (cyc > 0) begin @(negedge clk); #1; end
      if (stall_o) stall_cnt++;
      if (done_o) begin dones++; got_rd = rdata_o; got_berr = berr_o; end
      if (bif.bus_req) begin
        req_cyc++;
        if (!prev_req) rises++;
        if (req_cyc == 1) begin
          chk1("bus_we", bif.bus_we, !ld);
          chk("bus_be", {28'd0, bif.bus_be}, {28'd0, be});
          chk("bus_addr", bif.bus_addr, {a[31:2], 2'b00});
          if (!ld) chk("bus_wdata", bif.bus_wdata, bw);
        end
        bif.bus_ack = (req_cyc == ack_after);
        if (req_cyc == flush_cyc) begin flush_i = 1'b1; valid_i = 1'b0; end
        else flush_i = 1'b0;
      end else begin
        bif.bus_ack = 1'b0;
        flush_i     = 1'b0;
        if (req_cyc > 0 && !stall_o) fin = 1'b1;
      end
      prev_req = bif.bus_req;
    end
    chk1("completed_in_bound", fin, 1'b1);
    chk("req_cycles", req_cyc, exp_req);
    chk("req_rises", rises, 1);
    chk("stall_cycles", stall_cnt, exp_req + 1);
    chk("done_pulses", dones, exp_done ? 1 : 0);
    if (exp_done) begin
      chk1("berr", got_berr, exp_berr);
      if (!exp_berr) chk("rdata", got_rd, ld ? lr : 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_i = 1'b0; flush_i = 1'b0; bif.bus_ack = 1'b0;
      #1;
      chk1("idle_no_req", bif.bus_req, 1'b0);
      chk1("idle_no_done", done_o, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; op_i = 4'd0; addr_i = 32'd0; wdata_i = 32'd0;
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_req", bif.bus_req, 1'b0);
    chk1("rst_we", bif.bus_we, 1'b0);
    chk("rst_be", {28'd0, bif.bus_be}, 32'd0);
    chk("rst_addr", bif.bus_addr, 32'd0);
    chk("rst_wdata", bif.bus_wdata, 32'd0);
    chk1("rst_done", done_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk1("rst_berr", berr_o, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    run_op(4'd5, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 0);  // LW, stall 4 cycles
    run_op(4'd1, 32'h0000_0103, 32'h0, 32'h8012_3456, 1, 0);  // LB
    run_op(4'd2, 32'h0000_0103, 32'h0, 32'h8012_3456, 2, 0);  // LBU
    run_op(4'd7, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 2, 0);  // SH
    run_op(4'd3, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 1, 0);  // LH upper half
    run_op(4'd4, 32'h0000_0000, 32'h0, 32'h8001_8FFF, 1, 0);  // LHU lower half
    run_op(4'd5, 32'h0000_0101, 32'h0, 32'h0, 1, 0);          // LW misaligned
    run_op(4'd8, 32'h0000_0102, 32'h0, 32'h0, 1, 0);          // SW misaligned
    run_op(4'd5, 32'h0000_0300, 32'h0, 32'h1111_2222, 3, 1);  // flushed while in REQ
    run_op(4'd5, 32'h0000_0400, 32'h0, 32'h0, 0, 0);          // no ack: timeout
    run_op(4'd5, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 1, 0);  // back-to-back LW/SW
    run_op(4'd8, 32'h0000_0504, 32'h8765_4321, 32'h0, 1, 0);
    idle(3);

    // flush_i in IDLE blocks both the start and the address-error flags
    @(negedge clk);
    valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h0000_0101; flush_i = 1'b1;
    #1;
    chk1("flush_idle_adel", adel_o, 1'b0);
    @(negedge clk);
    addr_i = 32'h0000_0100;
    #1;
    chk1("flush_idle_stall", stall_o, 1'b0);
    @(negedge clk);
    #1;
    chk1("flush_idle_req", bif.bus_req, 1'b0);
    idle(1);

    // reset while a request is outstanding
    @(negedge clk);
    valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h0000_0040; bif.bus_ack = 1'b0;
    @(negedge clk);
    #1;
    chk1("pre_rst_req", bif.bus_req, 1'b1);
    rst = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk1("mid_rst_req", bif.bus_req, 1'b0);
    chk1("mid_rst_stall", stall_o, 1'b0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  r_op;
      logic [31:0] r_a, r_wd, r_rd;
      int          r_ack, r_fl;
      r_op  = 4'($urandom_range(0, 10));
      r_a   = $urandom;
      r_wd  = $urandom;
      r_rd  = $urandom;
      r_ack = $urandom_range(1, 5);
      r_fl  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      run_op(r_op, r_a, r_wd, r_rd, r_ack, r_fl);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
